// File: rtl/dsp_mac_pkg.sv
// Shared constants, FSM state and in-flight tag type for the DSP MAC
// arbiter.
package dsp_mac_pkg;

    localparam int AW_DEF = 18;
    localparam int PW     = 48;
    localparam int BW     = 16;
    localparam int IDW    = 3;

    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic           valid;
        logic           last;
        logic [IDW-1:0] id;
        logic [BW-1:0]  beats;
    } tag_t;

    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (v == '1) ? v : v + BW'(1);
    endfunction

endpackage

// File: rtl/dsp_mac_arbiter_tag_pipe.sv
// Fixed-depth shift register of in-flight beat tags, kept in step with
// the DSP slice pipeline.
module mac_tag_pipe
    import dsp_mac_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic clk_i,
    input  logic clr_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_arbiter.sv
// Round-robin burst arbiter sharing one DSP MAC slice among NREQ requesters.
// Optional DSP_MAC_CE_GATE_EN gates the slice clock enable while idle.
module dsp_mac_arbiter
    import dsp_mac_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = 4,
    parameter int AW       = AW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*AW-1:0]       req_a,
    input  logic [NREQ*AW-1:0]       req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [AW-1:0]            dsp_a,
    output logic [AW-1:0]            dsp_b,
    output logic [7:0]               dsp_opmode,
    output logic                     dsp_ce,
    input  logic [PW-1:0]            dsp_p,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [PW-1:0]            res_p,
    output logic [BW-1:0]            res_beats
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   a_q, a_d;
    logic [AW-1:0]   b_q, b_d;
    logic [7:0]      opm_q, opm_d;

    logic            res_valid_q;
    logic [IW-1:0]   res_id_q;
    logic [PW-1:0]   res_p_q;
    logic [BW-1:0]   res_beats_q;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            accept;
    logic            sel_last;
    logic [AW-1:0]   sel_a;
    logic [AW-1:0]   sel_b;
    tag_t            tag_in;
    tag_t            tag_out;

    // First valid requester strictly after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel_a    = req_a[int'(grant_q)*AW +: AW];
    assign sel_b    = req_b[int'(grant_q)*AW +: AW];
    assign sel_last = req_last[grant_q];
    assign accept   = (state_q == BURST) && req_valid[grant_q]
                      && ready_q[grant_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        opm_d   = OPM_HOLD;
        tag_in  = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = BURST;
                    grant_d       = pick;
                    ptr_d         = pick;
                    ready_d       = '0;
                    ready_d[pick] = 1'b1;
                    cnt_d         = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    a_d          = sel_a;
                    b_d          = sel_b;
                    opm_d        = (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
                    cnt_d        = sat_inc(cnt_q);
                    tag_in.valid = 1'b1;
                    tag_in.last  = sel_last;
                    tag_in.id    = IDW'(grant_q);
                    tag_in.beats = sat_inc(cnt_q);
                    if (sel_last) begin
                        state_d = IDLE;
                        ready_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= IW'(NREQ - 1);
            ready_q     <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opm_q       <= OPM_HOLD;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_p_q     <= '0;
            res_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            opm_q       <= opm_d;
            res_valid_q <= tag_out.valid && tag_out.last;
            if (tag_out.valid && tag_out.last) begin
                res_id_q    <= IW'(tag_out.id);
                res_p_q     <= dsp_p;
                res_beats_q <= tag_out.beats;
            end
        end
    end

    mac_tag_pipe #(
        .DEPTH (PIPE_LAT + 1)
    ) u_tag_pipe (
        .clk_i (clk),
        .clr_i (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

`ifdef DSP_MAC_CE_GATE_EN
    localparam int DW = $clog2(PIPE_LAT + 2);

    // Non-zero exactly while some accepted beat is still in the tag pipe.
    logic [DW-1:0] drain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_q <= '0;
        end else if (accept) begin
            drain_q <= DW'(PIPE_LAT + 1);
        end else if (drain_q != '0) begin
            drain_q <= drain_q - DW'(1);
        end
    end

    assign dsp_ce = (state_q != IDLE) || (drain_q != '0);
`else
    assign dsp_ce = 1'b1;
`endif

    assign req_ready  = ready_q;
    assign dsp_a      = a_q;
    assign dsp_b      = b_q;
    assign dsp_opmode = opm_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_p      = res_p_q;
    assign res_beats  = res_beats_q;

endmodule

// File: tb/tb_dsp_mac_arbiter.sv
// Directed bench for dsp_mac_arbiter with a behavioural slice model
// that honours opmode and clock enable.
module tb_dsp_mac_arbiter;

    localparam int NREQ = 4;
    localparam int PL   = 4;
    localparam int AW   = 18;
    localparam int IW   = 2;
`ifdef DSP_MAC_CE_GATE_EN
    localparam logic CE_IDLE = 1'b0;
`else
    localparam logic CE_IDLE = 1'b1;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*AW-1:0]   req_a;
    logic [NREQ*AW-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [AW-1:0]        dsp_a;
    logic [AW-1:0]        dsp_b;
    logic [7:0]           dsp_opmode;
    logic                 dsp_ce;
    logic [47:0]          dsp_p;
    logic                 res_valid;
    logic [IW-1:0]        res_id;
    logic [47:0]          res_p;
    logic [15:0]          res_beats;

    int checks  = 0;
    int errors  = 0;
    int res_cnt = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [47:0]   p;
        logic [15:0]   beats;
    } res_t;
    res_t res_q[$];

    always #5 clk = ~clk;

    dsp_mac_arbiter #(
        .NREQ(NREQ), .PIPE_LAT(PL), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_p(dsp_p),
        .res_valid(res_valid), .res_id(res_id),
        .res_p(res_p), .res_beats(res_beats)
    );

    // Slice model: pins sampled, PL-1 further stages, then P register.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [7:0]    op;
    } stg_t;
    stg_t        stg [PL-1];
    logic [47:0] p_m;
    assign dsp_p = p_m;

    function automatic logic [47:0] slice_f(input stg_t s, input logic [47:0] p);
        logic signed [47:0] m;
        m = $signed({{30{s.a[AW-1]}}, s.a}) * $signed({{30{s.b[AW-1]}}, s.b});
        case (s.op)
            8'h01:   return m;
            8'h09:   return p + m;
            default: return p;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            p_m <= '0;
            for (int i = 0; i < PL-1; i++) stg[i] <= '0;
        end else if (dsp_ce) begin
            p_m    <= slice_f(stg[PL-2], p_m);
            stg[0] <= {dsp_a, dsp_b, dsp_opmode};
            for (int i = 1; i < PL-1; i++) stg[i] <= stg[i-1];
        end
    end

    always @(negedge clk) begin
        if (res_valid) begin
            res_cnt++;
            res_q.push_back({res_id, res_p, res_beats});
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_dsp_a", dsp_a, 0);
        chk("rst_dsp_b", dsp_b, 0);
        chk("rst_opmode", dsp_opmode, 8'h08);
        chk("rst_ce", dsp_ce, CE_IDLE);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_p", res_p, 0);
        chk("rst_res_beats", res_beats, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        int            id;
        int            n;
        logic [AW-1:0] a [4];
        logic [AW-1:0] b [4];
        int            gap_at;
        int            gap_n;
        logic [47:0]   p;
        int            beats;
    } vec_t;

    function automatic vec_t mk(int id, int n, int a0, int b0, int a1, int b1,
                                int a2, int b2, int a3, int b3,
                                int gat, int gn, longint p, int beats);
        vec_t v;
        v.id = id;  v.n = n;
        v.a[0] = AW'(a0); v.b[0] = AW'(b0);
        v.a[1] = AW'(a1); v.b[1] = AW'(b1);
        v.a[2] = AW'(a2); v.b[2] = AW'(b2);
        v.a[3] = AW'(a3); v.b[3] = AW'(b3);
        v.gap_at = gat; v.gap_n = gn;
        v.p = 48'(p); v.beats = beats;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int t;
        logic [NREQ-1:0] oh;
        string s;
        oh = NREQ'(1) << v.id;
        s  = $sformatf("v%0d", idx);
        for (int k = 0; k < v.n; k++) begin
            if (k > 0 && k == v.gap_at) begin
                req_valid[v.id] = 1'b0;
                for (int g = 0; g < v.gap_n; g++) begin
                    @(negedge clk);
                    chk({s, "_bubble_op"}, dsp_opmode, 8'h08);
                    chk({s, "_bubble_grant"}, req_ready, oh);
                    chk({s, "_bubble_a"}, dsp_a, v.a[k-1]);
                end
            end
            req_a[v.id*AW +: AW] = v.a[k];
            req_b[v.id*AW +: AW] = v.b[k];
            req_last[v.id]       = (k == v.n - 1);
            req_valid[v.id]      = 1'b1;
            t = 0;
            while (!req_ready[v.id] && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) begin
                chk({s, "_ready_timeout"}, 1, 0);
                req_valid = '0;
                req_last  = '0;
                return;
            end
            chk({s, "_ready_onehot"}, req_ready, oh);
            @(negedge clk);
            chk({s, "_opmode"}, dsp_opmode, (k == 0) ? 8'h01 : 8'h09);
            chk({s, "_dsp_a"}, dsp_a, v.a[k]);
            chk({s, "_dsp_b"}, dsp_b, v.b[k]);
        end
        req_valid[v.id] = 1'b0;
        req_last[v.id]  = 1'b0;
        t = 0;
        while (!res_valid && t < PL + 8) begin
            @(negedge clk);
            t++;
        end
        chk({s, "_latency"}, t, PL + 1);
        chk({s, "_res_p"}, res_p, v.p);
        chk({s, "_res_id"}, res_id, v.id);
        chk({s, "_res_beats"}, res_beats, v.beats);
        @(negedge clk);
        chk({s, "_res_pulse"}, res_valid, 0);
    endtask

    vec_t vt [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        int nacc;
        int cnt0;
        int exp_ids [4];

        vt[0] = mk(0, 3, 2, 3, 4, 5, -1, 7, 0, 0, 0, 0, 19, 3);
        vt[1] = mk(2, 4, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 4, 4);
        vt[2] = mk(1, 1, -3, 5, 0, 0, 0, 0, 0, 0, 0, 0, -15, 1);
        vt[3] = mk(3, 3, 131071, 131071, 131071, 131071, 131071, 131071,
                   0, 0, 0, 0, 64'd51538821123, 3);
        vt[4] = mk(0, 2, -131072, -131072, 2, -3, 0, 0, 0, 0, 0, 0,
                   64'd17179869178, 2);
        exp_ids = '{1, 3, 1, 3};

        req_a = '0;
        req_b = '0;
        do_reset();
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i], i);
        end

        // Two contending requesters, single-beat bursts.
        do_reset();
        res_q.delete();
        req_a[1*AW +: AW] = 18'd1; req_b[1*AW +: AW] = 18'd1;
        req_a[3*AW +: AW] = 18'd1; req_b[3*AW +: AW] = 18'd1;
        req_last[1] = 1'b1; req_last[3] = 1'b1;
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        nacc = 0;
        t = 0;
        while (nacc < 4 && t < 100) begin
            chk("rr_ready_overlap", $countones(req_ready) > 1, 0);
            if (|(req_ready & req_valid)) nacc++;
            @(negedge clk);
            t++;
        end
        req_valid = '0;
        req_last  = '0;
        repeat (PL + 4) @(negedge clk);
        chk("rr_res_count", res_q.size(), 4);
        for (int i = 0; i < 4 && i < res_q.size(); i++) begin
            chk($sformatf("rr_id%0d", i), res_q[i].id, exp_ids[i]);
            chk($sformatf("rr_p%0d", i), res_q[i].p, 1);
            chk($sformatf("rr_beats%0d", i), res_q[i].beats, 1);
        end

        // Reset one cycle after the last beat is accepted.
        req_a[0 +: AW] = 18'd5;
        req_b[0 +: AW] = 18'd6;
        req_last[0]    = 1'b1;
        req_valid[0]   = 1'b1;
        t = 0;
        while (!req_ready[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rstb_grant", req_ready[0], 1);
        @(negedge clk);
        chk("rstb_opmode", dsp_opmode, 8'h01);
        chk("rstb_dsp_a", dsp_a, 5);
        cnt0 = res_cnt;
        do_reset();
        repeat (PL + 6) @(negedge clk);
        chk("rstb_no_result", res_cnt, cnt0);

        // Clock-enable behaviour around an idle gap.
        chk("ce_idle", dsp_ce, CE_IDLE);
        req_a[2*AW +: AW] = 18'd3;
        req_b[2*AW +: AW] = 18'd3;
        req_last[2]  = 1'b1;
        req_valid[2] = 1'b1;
        @(negedge clk);
        chk("ce_grant_ready", req_ready[2], 1);
        chk("ce_grant", dsp_ce, 1);
        @(negedge clk);
        chk("ce_first_op", dsp_ce, 1);
        chk("ce_opmode", dsp_opmode, 8'h01);
        req_valid = '0;
        req_last  = '0;
        t = 0;
        while (!res_valid && t < PL + 8) begin
            @(negedge clk);
            t++;
        end
        chk("ce_latency", t, PL + 1);
        chk("ce_res_p", res_p, 9);
        chk("ce_res_id", res_id, 2);
        repeat (2) @(negedge clk);
        chk("ce_drained", dsp_ce, CE_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
